// File: rtl/adder_tree_pipe.sv
// adder_tree_pipe: pipelined adder tree summing NUM operands of BITS each.
//
// One register stage per tree level (L = clog2(NUM) levels). Each level adds
// adjacent pairs; an odd leftover operand is passed through unchanged. The
// last level also applies optional saturation and registers o/sat together.
// Every stage has its own valid bit, so empty stages fill even while the
// output is stalled (bubbles collapse), and a full pipe still streams one
// result per cycle when ready_out is held high.
//
// Ports:
//   clk        clock
//   resetn     asynchronous active-low reset
//   valid      input operands valid
//   ready      tree can accept operands this cycle
//   i          packed operands, operand k = i[k*BITS +: BITS]
//   o          sum (OBITS wide: BITS when saturating, else BITS+clog2(NUM))
//   sat        result was clamped (always 0 when SATURATE=0)
//   valid_out  o/sat valid
//   ready_out  downstream accepts result
module adder_tree_pipe #(
   parameter int unsigned BITS     = 16,
   parameter int unsigned NUM      = 4,
   parameter bit          SIGNED   = 1'b1,
   parameter bit          SATURATE = 1'b0,
   localparam int unsigned OBITS   = SATURATE ? BITS : BITS + $clog2(NUM)
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                valid,
   output logic                ready,
   input  logic [NUM*BITS-1:0] i,
   output logic [OBITS-1:0]    o,
   output logic                sat,
   output logic                valid_out,
   input  logic                ready_out
);

   localparam int unsigned L  = $clog2(NUM);
   // Internal operands carry the full final width from the start; the upper
   // bits of early levels are plain sign/zero extension.
   localparam int unsigned WI = BITS + L;

   typedef logic [NUM-1:0][WI-1:0] vec_t;

   localparam logic [WI-1:0] SMAX = WI'((64'd1 << (BITS - 1)) - 64'd1);
   localparam logic [WI-1:0] SMIN = ~SMAX;
   localparam logic [WI-1:0] UMAX = WI'((64'd1 << BITS) - 64'd1);

   // One tree level: slot k = a[2k] + a[2k+1], or a[2k] alone if it is the
   // odd leftover. Slots past the live operand count stay zero.
   function automatic vec_t reduce_pairs(input vec_t a);
      vec_t r;
      r = '0;
      for (int unsigned k = 0; k < NUM; k++) begin
         if (2 * k + 1 < NUM) begin
            r[k] = a[2*k] + a[2*k+1];
         end else if (2 * k < NUM) begin
            r[k] = a[2*k];
         end
      end
      return r;
   endfunction

   logic [L-1:0]       v_q, v_d, load;
   logic [L:0]         upv;
   logic               drn;
   logic [BITS-1:0]    opnd;
   vec_t               ext;
   logic [1:0][WI-1:0] fin;
   logic [WI-1:0]      full;
   logic [OBITS-1:0]   o_d, o_q;
   logic               sat_d, sat_q;

   // Extend every operand to the internal width.
   always_comb begin
      ext  = '0;
      opnd = '0;
      for (int unsigned k = 0; k < NUM; k++) begin
         opnd   = i[k*BITS +: BITS];
         ext[k] = (SIGNED && opnd[BITS-1]) ? {{L{1'b1}}, opnd} : {{L{1'b0}}, opnd};
      end
   end

   // Upstream-valid of stage s is upv[s]: the input for stage 0, else v_q[s-1].
   assign upv = {v_q, valid};

   // Walk from the output back to the input: a stage drains exactly when its
   // successor loads, and the last stage drains on the output handshake.
   always_comb begin
      load  = '0;
      v_d   = v_q;
      ready = 1'b0;
      drn   = v_q[L-1] & ready_out;
      for (int s = int'(L) - 1; s >= 0; s--) begin
         load[s] = upv[s] & (~v_q[s] | drn);
         v_d[s]  = load[s] | (v_q[s] & ~drn);
         if (s == 0) begin
            ready = ~v_q[0] | drn;
         end
         drn = load[s];
      end
   end

   if (L > 1) begin : g_mid
      vec_t mid_q [L-1];

      always_ff @(posedge clk or negedge resetn) begin
         if (!resetn) begin
            for (int s = 0; s < int'(L) - 1; s++) begin
               mid_q[s] <= '0;
            end
         end else begin
            for (int s = 0; s < int'(L) - 1; s++) begin
               if (load[s]) begin
                  if (s == 0) begin
                     mid_q[s] <= reduce_pairs(ext);
                  end else begin
                     mid_q[s] <= reduce_pairs(mid_q[s-1]);
                  end
               end
            end
         end
      end

      // The final level always sees exactly two live operands.
      assign fin = mid_q[L-2][1:0];
   end else begin : g_direct
      assign fin = ext[1:0];
   end

   assign full = fin[0] + fin[1];

   always_comb begin
      o_d   = full[OBITS-1:0];
      sat_d = 1'b0;
      if (SATURATE) begin
         if (SIGNED) begin
            if ($signed(full) > $signed(SMAX)) begin
               o_d   = SMAX[OBITS-1:0];
               sat_d = 1'b1;
            end else if ($signed(full) < $signed(SMIN)) begin
               o_d   = SMIN[OBITS-1:0];
               sat_d = 1'b1;
            end
         end else if (full > UMAX) begin
            o_d   = UMAX[OBITS-1:0];
            sat_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         v_q   <= '0;
         o_q   <= '0;
         sat_q <= 1'b0;
      end else begin
         v_q <= v_d;
         if (load[L-1]) begin
            o_q   <= o_d;
            sat_q <= sat_d;
         end
      end
   end

   assign o         = o_q;
   assign sat       = sat_q;
   assign valid_out = v_q[L-1];

endmodule

// File: tb/tb_adder_tree_pipe.sv
// Bench for adder_tree_pipe: three configurations side by side.
//   dut 0: BITS=16 NUM=4 unsigned, full precision (OBITS=18)
//   dut 1: BITS=8  NUM=5 signed, saturating     (OBITS=8)
//   dut 2: BITS=8  NUM=8 signed, full precision (OBITS=11)
// A scoreboard checks every delivered result against an arithmetic model;
// directed sequences add literal expectations, latency and handshake checks.
module tb_adder_tree_pipe;

   typedef int ops_t [16];

   logic        clk;
   logic        resetn;
   logic [2:0]  valid_v;
   logic [2:0]  rout_v;
   wire  [2:0]  rdy_v;
   wire  [2:0]  vo_v;
   wire  [2:0]  sat_v;
   logic [63:0] i_a;
   logic [39:0] i_b;
   logic [63:0] i_c;
   wire  [17:0] o_a;
   wire  [7:0]  o_b;
   wire  [10:0] o_c;

   int bits_c [3] = '{16, 8, 8};
   int num_c  [3] = '{4, 5, 8};
   int sgn_c  [3] = '{0, 1, 1};
   int satc_c [3] = '{0, 1, 0};

   int     n_chk  = 0;
   int     n_fail = 0;
   longint sbq [3][$];
   int     delivered [3] = '{0, 0, 0};
   bit     held [3] = '{0, 0, 0};
   longint ho [3];
   bit     hs [3];

   adder_tree_pipe #(.BITS(16), .NUM(4), .SIGNED(1'b0), .SATURATE(1'b0)) u_a (
      .clk(clk), .resetn(resetn), .valid(valid_v[0]), .ready(rdy_v[0]), .i(i_a),
      .o(o_a), .sat(sat_v[0]), .valid_out(vo_v[0]), .ready_out(rout_v[0]));

   adder_tree_pipe #(.BITS(8), .NUM(5), .SIGNED(1'b1), .SATURATE(1'b1)) u_b (
      .clk(clk), .resetn(resetn), .valid(valid_v[1]), .ready(rdy_v[1]), .i(i_b),
      .o(o_b), .sat(sat_v[1]), .valid_out(vo_v[1]), .ready_out(rout_v[1]));

   adder_tree_pipe #(.BITS(8), .NUM(8), .SIGNED(1'b1), .SATURATE(1'b0)) u_c (
      .clk(clk), .resetn(resetn), .valid(valid_v[2]), .ready(rdy_v[2]), .i(i_c),
      .o(o_c), .sat(sat_v[2]), .valid_out(vo_v[2]), .ready_out(rout_v[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input longint got, input longint exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   function automatic logic [511:0] pack(input int bits, input ops_t v);
      logic [511:0] r;
      logic [511:0] t;
      longint       one;
      one = 1;
      r   = '0;
      for (int k = 0; k < 16; k++) begin
         t = 512'(longint'(v[k]) & ((one << bits) - 1));
         r = r | (t << (k * bits));
      end
      return r;
   endfunction

   // Plain arithmetic model: exact sum, then clamp; sat flag kept in bit 40.
   function automatic longint model_exp(input int d, input logic [511:0] ops);
      longint       sum, val, lo, hi, one;
      logic [511:0] t;
      bit           s;
      int           b, n, ob;
      one = 1;
      sum = 0;
      s   = 1'b0;
      b   = bits_c[d];
      n   = num_c[d];
      for (int k = 0; k < n; k++) begin
         t   = ops >> (k * b);
         val = longint'(t[63:0]) & ((one << b) - 1);
         if (sgn_c[d] != 0 && val >= (one << (b - 1))) val = val - (one << b);
         sum = sum + val;
      end
      if (satc_c[d] != 0) begin
         if (sgn_c[d] != 0) begin
            lo = -(one << (b - 1));
            hi = (one << (b - 1)) - 1;
         end else begin
            lo = 0;
            hi = (one << b) - 1;
         end
         if (sum > hi) begin sum = hi; s = 1'b1; end
         if (sum < lo) begin sum = lo; s = 1'b1; end
      end
      ob = (satc_c[d] != 0) ? b : b + $clog2(n);
      return (longint'(s) << 40) | (sum & ((one << ob) - 1));
   endfunction

   function automatic longint get_o(input int d);
      case (d)
         0:       return longint'(o_a);
         1:       return longint'(o_b);
         default: return longint'(o_c);
      endcase
   endfunction

   function automatic logic [511:0] get_i(input int d);
      logic [511:0] r;
      r = '0;
      case (d)
         0:       r[63:0] = i_a;
         1:       r[39:0] = i_b;
         default: r[63:0] = i_c;
      endcase
      return r;
   endfunction

   task automatic set_in(input int d, input bit v, input logic [511:0] ops);
      valid_v[d] = v;
      case (d)
         0:       i_a = ops[63:0];
         1:       i_b = ops[39:0];
         default: i_c = ops[63:0];
      endcase
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: sampled on the falling edge, so every handshake seen here
   // is exactly the one that completes on the next rising edge.
   always @(negedge clk) begin
      for (int d = 0; d < 3; d++) begin
         if (!resetn) begin
            sbq[d].delete();
            held[d] = 1'b0;
         end else begin
            if (held[d]) begin
               check($sformatf("hold_dut%0d", d),
                     (longint'(vo_v[d]) << 48) | (longint'(sat_v[d]) << 40) | get_o(d),
                     (longint'(1) << 48) | (longint'(hs[d]) << 40) | ho[d]);
            end
            held[d] = vo_v[d] && !rout_v[d];
            ho[d]   = get_o(d);
            hs[d]   = sat_v[d];
            if (vo_v[d]) begin
               if (sbq[d].size() == 0) begin
                  check($sformatf("spurious_dut%0d", d), 1, 0);
               end else if (rout_v[d]) begin
                  check($sformatf("sb_dut%0d", d),
                        (longint'(sat_v[d]) << 40) | get_o(d), sbq[d].pop_front());
                  delivered[d]++;
               end
            end
            if (valid_v[d] && rdy_v[d]) sbq[d].push_back(model_exp(d, get_i(d)));
         end
      end
   end

   function automatic logic [511:0] mk_ops(input int k);
      ops_t v;
      v    = '{default: 0};
      v[0] = k >>> 1;
      v[1] = k - (k >>> 1);
      return pack(16, v);
   endfunction

   // Single accept into an empty pipe; checks latency and the literal result.
   task automatic one_shot(input int d, input ops_t v, input longint exp_o, input bit exp_s,
                           input string name);
      int n;
      set_in(d, 1'b1, pack(bits_c[d], v));
      check({name, "_ready"}, rdy_v[d], 1);
      step();
      set_in(d, 1'b0, '0);
      n = 1;
      while (!vo_v[d] && n < 20) begin
         step();
         n++;
      end
      check({name, "_latency"}, n, $clog2(num_c[d]));
      check({name, "_o"}, get_o(d), exp_o);
      check({name, "_sat"}, sat_v[d], exp_s);
      step();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      ops_t v;
      int   sent, base, acc, n;
      bit   saw_low, any_vo;

      resetn  = 1'b0;
      valid_v = '0;
      rout_v  = '1;
      i_a     = '0;
      i_b     = '0;
      i_c     = '0;
      repeat (2) @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         check($sformatf("rst_vo_dut%0d", d), vo_v[d], 0);
         check($sformatf("rst_sat_dut%0d", d), sat_v[d], 0);
         check($sformatf("rst_o_dut%0d", d), get_o(d), 0);
         check($sformatf("rst_ready_dut%0d", d), rdy_v[d], 1);
      end
      resetn = 1'b1;
      step();

      // Basic sums and boundaries.
      v = '{0: 1, 1: 2, 2: 3, 3: 4, default: 0};
      one_shot(0, v, 10, 1'b0, "a_1234");
      v = '{0: 65535, 1: 65535, 2: 65535, 3: 65535, default: 0};
      one_shot(0, v, 'h3FFFC, 1'b0, "a_umax");
      v = '{0: 100, 1: 100, 2: 100, 3: -20, 4: -20, default: 0};
      one_shot(1, v, 'h7F, 1'b1, "b_satpos");
      v = '{0: -128, 1: -128, default: 0};
      one_shot(1, v, 'h80, 1'b1, "b_satneg");
      v = '{default: 0};
      one_shot(1, v, 0, 1'b0, "b_zero");
      v = '{0: 10, 1: 20, 2: -5, 3: 1, 4: 2, default: 0};
      one_shot(1, v, 28, 1'b0, "b_mixed");
      v = '{0: -128, 1: -128, 2: -128, 3: -128, 4: -128, 5: -128, 6: -128, 7: -128,
            default: 0};
      one_shot(2, v, 'h400, 1'b0, "c_maxneg");

      // Back-to-back stream, no stall: results 0..7 on consecutive cycles.
      for (int c = 0; c <= 8; c++) begin
         if (c < 8) begin
            set_in(0, 1'b1, mk_ops(c));
            check("b2b_ready", rdy_v[0], 1);
         end else begin
            set_in(0, 1'b0, '0);
         end
         step();
         if (c >= 1) begin
            check("b2b_vo", vo_v[0], 1);
            check("b2b_o", get_o(0), c - 1);
         end
      end
      repeat (3) step();

      // Same stream with the output stalled for a stretch.
      base    = delivered[0];
      sent    = 0;
      saw_low = 1'b0;
      for (int c = 0; c < 60 && sent < 8; c++) begin
         rout_v[0] = !(c >= 4 && c <= 9);
         set_in(0, 1'b1, mk_ops(sent));
         #1;
         acc = rdy_v[0];
         if (!rdy_v[0]) saw_low = 1'b1;
         step();
         if (acc != 0) sent++;
      end
      set_in(0, 1'b0, '0);
      rout_v[0] = 1'b1;
      n = 0;
      while (delivered[0] < base + 8 && n < 50) begin
         step();
         n++;
      end
      check("stall_ready_dropped", saw_low, 1);
      check("stall_delivered", delivered[0] - base, 8);
      check("stall_sb_empty", sbq[0].size(), 0);

      // Bubble collapse on the 8-operand tree.
      rout_v[2] = 1'b0;
      v = '{0: -128, 1: -128, 2: -128, 3: -128, 4: -128, 5: -128, 6: -128, 7: -128,
            default: 0};
      set_in(2, 1'b1, pack(8, v));
      step();
      set_in(2, 1'b0, '0);
      repeat (3) step();
      v = '{0: 1, 1: 2, 2: 3, 3: 4, 4: 5, 5: 6, 6: 7, 7: 8, default: 0};
      set_in(2, 1'b1, pack(8, v));
      check("bubble_ready", rdy_v[2], 1);
      step();
      set_in(2, 1'b0, '0);
      repeat (3) step();
      check("bubble_hold_vo", vo_v[2], 1);
      check("bubble_hold_o", get_o(2), 'h400);
      rout_v[2] = 1'b1;
      #1;
      check("bubble_first_o", get_o(2), 'h400);
      step();
      check("bubble_second_vo", vo_v[2], 1);
      check("bubble_second_o", get_o(2), 36);
      step();
      check("bubble_empty_vo", vo_v[2], 0);
      repeat (2) step();

      // Asynchronous reset with two saturating results in flight.
      v = '{0: 100, 1: 100, 2: 100, 3: -20, 4: -20, default: 0};
      set_in(1, 1'b1, pack(8, v));
      step();
      v = '{0: -128, 1: -128, default: 0};
      set_in(1, 1'b1, pack(8, v));
      step();
      set_in(1, 1'b0, '0);
      step();
      check("pre_rst_vo", vo_v[1], 1);
      check("pre_rst_sat", sat_v[1], 1);
      #2;
      resetn = 1'b0;
      #1;
      check("rst_async_vo", vo_v[1], 0);
      check("rst_async_sat", sat_v[1], 0);
      check("rst_async_o", get_o(1), 0);
      step();
      step();
      resetn = 1'b1;
      any_vo = 1'b0;
      for (int c = 0; c < 10; c++) begin
         step();
         if (vo_v != 3'b000) any_vo = 1'b1;
      end
      check("post_rst_no_stale", any_vo, 0);
      v = '{0: 1, 1: 2, 2: 3, 3: 4, 4: 5, default: 0};
      one_shot(1, v, 15, 1'b0, "b_after_rst");

      repeat (3) step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
